imem_loader: RTL and testbench

Byte-stream program loader that fills the instruction memory before the processor runs. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each completed word is issued as a single-cycle write to the instruction memory's write port at consecutive word-aligned byte addresses. The frame ends with a checksum, and the block reports done or error so the core can be held in reset until the program image is valid.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory byte-stream loader.
//   state_e        - loader FSM states
//   HDR_BYTES      - bytes in the frame header (16-bit word count, MSB first)
//   BYTES_PER_WORD - payload bytes per instruction word (big-endian)
//   CSUM_BYTES     - trailing checksum bytes (XOR of header and payload)
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CSUM_BYTES     = 1;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a framed byte stream.
//   Frame: 16-bit word count N (MSB first), N big-endian 32-bit words, 1 XOR checksum byte.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - begin a load (honoured in IDLE, DONE, ERROR)
//   in_valid, in_data   - byte stream input; in_ready accepts a byte
//   wr_en/wr_addr/wr_data - one-cycle instruction memory write
//   busy, done, error   - load status, decoded from the registered state
//   words_written       - writes issued in the current or last load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH     = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [7:0]                   in_data,
    output logic                         in_ready,
    output logic                         wr_en,
    output logic [31:0]                  wr_addr,
    output logic [31:0]                  wr_data,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [$clog2(DEPTH+1)-1:0]   words_written
);

    localparam int unsigned WW      = $clog2(DEPTH + 1);
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_e          state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [15:0]     word_cnt_q, word_cnt_d;
    logic [15:0]     count_q, count_d;
    logic [31:0]     asm_q, asm_d;
    logic [7:0]      csum_q, csum_d;
    logic            wr_en_q, wr_en_d;
    logic [31:0]     wr_addr_q, wr_addr_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic [WW-1:0]   ww_q, ww_d;

    logic            accept;
    logic [15:0]     hdr_count;
    logic [31:0]     word_nxt;

    // Status outputs depend only on the registered state.
    assign in_ready      = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign busy          = in_ready;
    assign done          = (state_q == ST_DONE);
    assign error         = (state_q == ST_ERROR);
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign words_written = ww_q;

    assign accept    = in_valid && in_ready;
    assign hdr_count = {count_q[15:8], in_data};
    assign word_nxt  = {asm_q[23:0], in_data};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        count_d    = count_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        ww_d       = ww_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d    = ST_HDR;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    csum_d     = '0;
                    ww_d       = '0;
                end
            end

            ST_HDR: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    if (byte_cnt_q != 2'(HDR_BYTES - 1)) begin
                        count_d[15:8] = in_data;
                        byte_cnt_d    = byte_cnt_q + 2'd1;
                    end else begin
                        count_d    = hdr_count;
                        byte_cnt_d = '0;
                        if ({1'b0, hdr_count} > DEPTH_W) begin
                            state_d = ST_ERROR;
                        end else if (hdr_count == '0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ in_data;
                    asm_d      = word_nxt;
                    // 2-bit counter wraps to 0 after the last byte of a word.
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = word_nxt;
                        wr_addr_d  = BASE_ADDR + {14'b0, word_cnt_q, 2'b00};
                        ww_d       = ww_q + WW'(1);
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_d == count_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end

            ST_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            count_q    <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ww_q       <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            count_q    <= count_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            ww_q       <= ww_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized frames for imem_loader, checked against
// a frame-level reference model (expected writes and checksum computed from the word list).
module tb_imem_loader;

    localparam int unsigned DEPTH     = 128;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int unsigned WW        = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic          wr_en;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [WW-1:0] words_written;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_words[$];
    logic [63:0] got_q[$];

    imem_loader #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Capture writes; loader is ready exactly while a load is in progress.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en === 1'b1) got_q.push_back({wr_addr, wr_data});
            chk("ready_eq_busy", {31'b0, in_ready}, {31'b0, busy});
        end
    end

    // All driving happens at negedges; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int duty);
        int guard = 0;
        while (duty < 100 && int'($urandom_range(99)) >= duty) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) chk("send_timeout", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference model: one write per word at BASE+4*i, checksum = XOR of all frame bytes.
    task automatic run_frame(input string tag, input logic [15:0] cnt, input int duty,
                             input logic [7:0] csum_flip);
        logic [7:0] cs;
        logic [7:0] b;
        bit         oversize;
        bit         good;
        int         g;
        int         nexp;
        got_q.delete();
        oversize = (int'(cnt) > int'(DEPTH));
        good     = !oversize && (csum_flip == 8'h00);
        do_start();
        chk({tag, "_busy_after_start"}, {31'b0, busy}, 32'd1);
        chk({tag, "_flags_cleared"}, {30'b0, done, error}, 32'd0);
        cs = cnt[15:8] ^ cnt[7:0];
        send_byte(cnt[15:8], duty);
        send_byte(cnt[7:0], duty);
        if (!oversize) begin
            for (int i = 0; i < int'(cnt); i++) begin
                for (int k = 3; k >= 0; k--) begin
                    b  = 8'(exp_words[i] >> (8 * k));
                    cs = cs ^ b;
                    send_byte(b, duty);
                end
            end
            send_byte(cs ^ csum_flip, duty);
        end
        g = 0;
        while (done !== 1'b1 && error !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_end_latency"}, g, 0);
        chk({tag, "_done"}, {31'b0, done}, {31'b0, good});
        chk({tag, "_error"}, {31'b0, error}, {31'b0, !good});
        chk({tag, "_in_ready_idle"}, {31'b0, in_ready}, 32'd0);
        nexp = oversize ? 0 : int'(cnt);
        chk({tag, "_words_written"}, 32'(words_written), nexp);
        chk({tag, "_num_writes"}, got_q.size(), nexp);
        for (int i = 0; i < nexp && i < got_q.size(); i++) begin
            chk({tag, "_addr"}, got_q[i][63:32], BASE_ADDR + 32'(4 * i));
            chk({tag, "_data"}, got_q[i][31:0], exp_words[i]);
        end
    endtask

    task automatic rand_words(input int n);
        exp_words.delete();
        for (int i = 0; i < n; i++) exp_words.push_back($urandom);
    endtask

    initial begin
        int n;
        #1;
        chk("reset_outputs", {in_ready, wr_en, busy, done, error, 27'(words_written)}, 32'd0);
        chk("reset_addr", wr_addr, 32'd0);
        chk("reset_data", wr_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_not_ready", {31'b0, in_ready}, 32'd0);

        // Bytes offered in IDLE are not consumed and do not start a load.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("idle_stays_idle", {29'b0, busy, done, error}, 32'd0);

        exp_words.delete();
        exp_words.push_back(32'h2008_0005);
        exp_words.push_back(32'h0109_4820);
        run_frame("plan2", 16'd2, 100, 8'h00);
        run_frame("plan2_stall", 16'd2, 30, 8'h00);

        // Count 0: done exactly 3 edges after the start edge.
        got_q.delete();
        do_start();
        send_byte(8'h00, 100);
        chk("zero_done_early1", {31'b0, done}, 32'd0);
        send_byte(8'h00, 100);
        chk("zero_done_early2", {31'b0, done}, 32'd0);
        send_byte(8'h00, 100);
        chk("zero_done", {31'b0, done}, 32'd1);
        chk("zero_writes", got_q.size(), 0);
        chk("zero_ww", 32'(words_written), 32'd0);

        // Oversize count: error immediately after the 2nd header byte.
        exp_words.delete();
        run_frame("oversize", 16'h0081, 100, 8'h00);
        // DEPTH itself is legal.
        rand_words(int'(DEPTH));
        run_frame("full_depth", 16'(DEPTH), 100, 8'h00);

        rand_words(1);
        run_frame("bad_csum", 16'd1, 100, 8'h01);
        run_frame("recover", 16'd1, 60, 8'h00);

        // Reset mid-load after 2 payload bytes.
        got_q.delete();
        do_start();
        send_byte(8'h00, 100);
        send_byte(8'h02, 100);
        send_byte(8'h12, 100);
        send_byte(8'h34, 100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {in_ready, wr_en, busy, done, error, 27'(words_written)}, 32'd0);
        chk("midrst_addr", wr_addr, 32'd0);
        chk("midrst_data", wr_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rand_words(3);
        run_frame("after_reset", 16'd3, 100, 8'h00);

        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(1, 8));
            rand_words(n);
            run_frame("random", 16'(n), int'($urandom_range(20, 100)),
                      (t % 3 == 2) ? 8'(1 << $urandom_range(7)) : 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
